// File: rtl/bus_pkg.sv
// Shared definitions for the system bus: default widths, arbiter state
// encodings and the slave region codes used by the address decoder.
package bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_M0_GRANT = 1'b0,
        ST_M1_GRANT = 1'b1
    } arb_state_e;

    // Slave region codes seen by the address decoder
    typedef enum logic [2:0] {
        RGN_MATRIX = 3'b000,
        RGN_RAM_A  = 3'b001,
        RGN_RAM_B  = 3'b010,
        RGN_RAM_C  = 3'b011
    } bus_region_e;

endpackage

// File: rtl/bus_arb_timer.sv
// Hold counter for the bus arbiter's contention timeout.
// Counts consecutive cycles in which both masters request. expire is
// raised on the TIMEOUT-th such cycle so the next edge preempts the owner.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   contend     both masters are requesting this cycle
//   expire      owner has held the bus for TIMEOUT contended cycles
module bus_arb_timer
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic contend,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign expire = contend && (count == CNT_W'(TIMEOUT - 1));

    // A grant change only ever happens on a non-contended cycle (owner
    // dropped req) or on expiry, so both of those clearing the count
    // covers the "clear on grant change" case without seeing the grant.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (contend && !expire)
            count <= count + 1'b1;
        else
            count <= '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared system bus. M0 (CPU) and M1 (DMA /
// matrix engine) request with level signals; a single registered grant
// selects whose req/wr/address/data drive the bus. The grant parks on M0.
// Optional feature: define BUS_ARB_TIMEOUT_EN to preempt an owner after
// TIMEOUT consecutive contended cycles (otherwise owners may starve).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   M0_req/M0_wr/M0_address/M0_dout     master 0 request and payload
//   M1_req/M1_wr/M1_address/M1_dout     master 1 request and payload
//   M0_grant, M1_grant                  registered grant (exactly one high)
//   M_req/M_wr/M_address/M_dout         owner's signals onto the bus
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic              M_req,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_dout
);

    arb_state_e state;
    logic       expire;

`ifdef BUS_ARB_TIMEOUT_EN
    logic contend;

    // Whoever owns the bus, contention means both are requesting.
    assign contend = M0_req & M1_req;

    bus_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .contend (contend),
        .expire  (expire)
    );
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_M0_GRANT;
        end else begin
            case (state)
                ST_M0_GRANT: if (expire || (!M0_req && M1_req)) state <= ST_M1_GRANT;
                ST_M1_GRANT: if (expire || !M1_req)             state <= ST_M0_GRANT;
                default:                                          state <= ST_M0_GRANT;
            endcase
        end
    end

    assign M0_grant = (state == ST_M0_GRANT);
    assign M1_grant = ~M0_grant;

    // Mux selects from the registered grant only, so a bus cycle never
    // mixes the two masters' signals.
    assign M_req     = M0_grant ? M0_req     : M1_req;
    assign M_wr      = M0_grant ? M0_wr      : M1_wr;
    assign M_address = M0_grant ? M0_address : M1_address;
    assign M_dout    = M0_grant ? M0_dout    : M1_dout;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              M0_req, M0_wr, M1_req, M1_wr;
    logic [ADDR_W-1:0] M0_address, M1_address;
    logic [DATA_W-1:0] M0_dout, M1_dout;
    logic              M0_grant, M1_grant, M_req, M_wr;
    logic [ADDR_W-1:0] M_address;
    logic [DATA_W-1:0] M_dout;

    int n_vec = 0;
    int n_err = 0;

    // Reference: which master owns the bus, and how many consecutive
    // contended cycles the current owner has held it.
    int owner = 0;
    int held  = 0;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant),
        .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Apply the arbitration rules to the inputs present at this edge.
    task automatic model_edge();
        bit own_req, oth_req;
        if (reset) begin
            owner = 0;
            held  = 0;
        end else begin
            own_req = (owner == 0) ? M0_req : M1_req;
            oth_req = (owner == 0) ? M1_req : M0_req;
`ifdef BUS_ARB_TIMEOUT_EN
            if (own_req && oth_req && held == TIMEOUT - 1) begin
                owner = 1 - owner;
                held  = 0;
            end else begin
`endif
                if (!own_req && (owner == 1 || oth_req)) owner = 1 - owner;
                held = (own_req && oth_req) ? held + 1 : 0;
`ifdef BUS_ARB_TIMEOUT_EN
            end
`endif
        end
    endtask

    // One clock: model follows the edge, then every output is compared.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("M0_grant", 64'(M0_grant), 64'(owner == 0));
        chk("M1_grant", 64'(M1_grant), 64'(owner == 1));
        chk("M_req",    64'(M_req),     64'(owner == 0 ? M0_req : M1_req));
        chk("M_wr",     64'(M_wr),      64'(owner == 0 ? M0_wr : M1_wr));
        chk("M_address",64'(M_address), 64'(owner == 0 ? M0_address : M1_address));
        chk("M_dout",   64'(M_dout),    64'(owner == 0 ? M0_dout : M1_dout));
    endtask

    task automatic rand_payload();
        M0_wr = 1'($urandom); M1_wr = 1'($urandom);
        M0_address = 8'($urandom); M1_address = 8'($urandom);
        M0_dout = $urandom; M1_dout = $urandom;
    endtask

    initial begin
        reset = 1'b1; M0_req = 1'b0; M1_req = 1'b0;
        rand_payload();
        M0_address = 8'h10;

        // Reset held for two cycles
        tick(); tick();
        chk("rst_m0_grant", 64'(M0_grant), 64'd1);
        chk("rst_m1_grant", 64'(M1_grant), 64'd0);
        chk("rst_addr", 64'(M_address), 64'h10);
        reset = 1'b0;

        // Hand-off to M1 (RAM A region)
        M1_req = 1'b1; M1_address = 8'h25;
        tick();
        chk("handoff_grant", 64'(M1_grant), 64'd1);
        chk("handoff_addr", 64'(M_address), 64'h25);

        // Park: M1 drops with M0 idle -> back to M0, bus idle
        M1_req = 1'b0;
        tick();
        chk("park_grant", 64'(M0_grant), 64'd1);
        chk("park_req", 64'(M_req), 64'd0);

        // Contention from park: M0 keeps it while requesting
        M0_req = 1'b1; M1_req = 1'b1;
        tick(); tick();
        chk("contend_m0_holds", 64'(M0_grant), 64'd1);
        M0_req = 1'b0;
        tick();
        chk("contend_handover", 64'(M1_grant), 64'd1);

        // Reset mid-transaction while M1 writes
        M1_wr = 1'b1; M0_wr = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_grant", 64'(M0_grant), 64'd1);
        chk("midrst_wr", 64'(M_wr), 64'd0);

        // Timeout: M1 owns, then both hold req
        M0_req = 1'b0; M1_req = 1'b1;
        tick();
        chk("to_m1_owns", 64'(M1_grant), 64'd1);
        M0_req = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        tick(); tick(); tick();
        chk("to_before", 64'(M1_grant), 64'd1);
        tick();
        chk("to_switch", 64'(M0_grant), 64'd1);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("no_to_m1_keeps", 64'(M1_grant), 64'd1);
`endif

        // Randomized traffic; requests tend to persist for a few cycles
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) M0_req = 1'($urandom);
            if ($urandom_range(0, 3) == 0) M1_req = 1'($urandom);
            rand_payload();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
